// File: rtl/up_down_sequencer.sv
// ============================================================================
//  Module      : up_down_sequencer
//  Description : Command-driven up/down counter sequencer. A command loads a
//                start value and steps the count once every DIV clocks toward
//                an end value, either stopping there (one-shot) or reversing
//                between start and end indefinitely (bounce).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module up_down_sequencer #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [WIDTH-1:0] CMD_START,
    input  logic [WIDTH-1:0] CMD_END,
    input  logic             CMD_UPDN,
    input  logic             CMD_MODE,
    input  logic             PAUSE,
    input  logic             ABORT,
    output logic [WIDTH-1:0] COUNT,
    output logic             UPDN,
    output logic             BUSY,
    output logic             DONE,
    output logic             TURN
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    // Divider terminal value; DIV is limited to 1..255 so 8 bits suffice.
    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] count_q,  count_d;
    logic [WIDTH-1:0] start_q,  start_d;
    logic [WIDTH-1:0] end_q,    end_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [7:0]       div_q,    div_d;
    logic             updn_q,   updn_d;
    logic             mode_q,   mode_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             turn_q,   turn_d;
    logic [WIDTH-1:0] count_step;

    // Next-state logic: command acceptance, divider ticks, stepping and reversal.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        start_d    = start_q;
        end_d      = end_q;
        target_d   = target_q;
        div_d      = div_q;
        updn_d     = updn_q;
        mode_d     = mode_q;
        done_d     = 1'b0;
        turn_d     = 1'b0;
        count_step = updn_q ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));

        case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    count_d  = CMD_START;
                    updn_d   = CMD_UPDN;
                    start_d  = CMD_START;
                    end_d    = CMD_END;
                    mode_d   = CMD_MODE;
                    target_d = CMD_END;
                    div_d    = 8'd0;
                    // A zero-length sequence completes without ever stepping.
                    if (CMD_START == CMD_END) begin
                        state_d = S_FINISH;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                // Abort outranks both pause and a pending tick; count and direction hold.
                if (ABORT) begin
                    state_d = S_IDLE;
                end else if (!PAUSE) begin
                    if (div_q == DIV_LAST) begin
                        div_d   = 8'd0;
                        count_d = count_step;
                        if (count_step == target_q) begin
                            if (!mode_q) begin
                                state_d = S_FINISH;
                                done_d  = 1'b1;
                            end else begin
                                updn_d   = ~updn_q;
                                target_d = (target_q == end_q) ? start_q : end_q;
                                turn_d   = 1'b1;
                            end
                        end
                    end else begin
                        div_d = div_q + 8'd1;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; reset forces an idle, empty sequencer.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            start_q  <= '0;
            end_q    <= '0;
            target_q <= '0;
            div_q    <= 8'd0;
            updn_q   <= 1'b1;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            turn_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            start_q  <= start_d;
            end_q    <= end_d;
            target_q <= target_d;
            div_q    <= div_d;
            updn_q   <= updn_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            turn_q   <= turn_d;
        end
    end

    assign CMD_READY = (state_q == S_IDLE);
    assign COUNT     = count_q;
    assign UPDN      = updn_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign TURN      = turn_q;

endmodule

`default_nettype wire

// File: tb/tb_up_down_sequencer.sv
// ============================================================================
//  Module      : tb_up_down_sequencer
//  Description : Scoreboard bench for up_down_sequencer. Two instances (DIV=1
//                and DIV=3) are driven in turn; the driver predicts each
//                cycle's outputs from a sequence-level model and queues them,
//                a monitor pops and compares after every rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_up_down_sequencer;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    typedef struct packed {
        logic [W-1:0] count;
        logic         updn;
        logic         busy;
        logic         done;
        logic         turn;
        logic         ready;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [1:0]          cmd_valid, cmd_updn, cmd_mode, pause, abort;
    logic [1:0][W-1:0]   cmd_start, cmd_end;
    logic [1:0]          cmd_ready, updn, busy, done, turn;
    logic [1:0][W-1:0]   count;

    exp_t q0[$];
    exp_t q1[$];
    int   checks   = 0;
    int   failures = 0;

    int   m_count[2];
    bit   m_dir[2];
    bit   m_fin[2];

    always #5 clk = ~clk;

    up_down_sequencer #(.WIDTH(W), .DIV(1)) dut_div1 (
        .CLK(clk), .RESET(rst_n),
        .CMD_VALID(cmd_valid[0]), .CMD_READY(cmd_ready[0]),
        .CMD_START(cmd_start[0]), .CMD_END(cmd_end[0]),
        .CMD_UPDN(cmd_updn[0]), .CMD_MODE(cmd_mode[0]),
        .PAUSE(pause[0]), .ABORT(abort[0]),
        .COUNT(count[0]), .UPDN(updn[0]), .BUSY(busy[0]),
        .DONE(done[0]), .TURN(turn[0])
    );

    up_down_sequencer #(.WIDTH(W), .DIV(3)) dut_div3 (
        .CLK(clk), .RESET(rst_n),
        .CMD_VALID(cmd_valid[1]), .CMD_READY(cmd_ready[1]),
        .CMD_START(cmd_start[1]), .CMD_END(cmd_end[1]),
        .CMD_UPDN(cmd_updn[1]), .CMD_MODE(cmd_mode[1]),
        .PAUSE(pause[1]), .ABORT(abort[1]),
        .COUNT(count[1]), .UPDN(updn[1]), .BUSY(busy[1]),
        .DONE(done[1]), .TURN(turn[1])
    );

    function automatic exp_t mk(int c, bit u, bit b, bit d, bit t);
        exp_t e;
        e.count = W'(c);
        e.updn  = u;
        e.busy  = b;
        e.done  = d;
        e.turn  = t;
        e.ready = !b;
        return e;
    endfunction

    task automatic compare(int inst, string name, exp_t e);
        exp_t a;
        a = {count[inst], updn[inst], busy[inst], done[inst], turn[inst], cmd_ready[inst]};
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s inst%0d t=%0t got count=%0d updn=%b busy=%b done=%b turn=%b ready=%b expected count=%0d updn=%b busy=%b done=%b turn=%b ready=%b",
                     name, inst, $time, a.count, a.updn, a.busy, a.done, a.turn, a.ready,
                     e.count, e.updn, e.busy, e.done, e.turn, e.ready);
        end
    endtask

    // Monitor: one expectation per driven cycle, compared just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) compare(0, "cycle", q0.pop_front());
            if (q1.size() > 0) compare(1, "cycle", q1.pop_front());
        end
    end

    task automatic push(int inst, int c, bit u, bit b, bit d, bit t);
        if (inst == 0) q0.push_back(mk(c, u, b, d, t));
        else           q1.push_back(mk(c, u, b, d, t));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic noise(int inst, bit v);
        cmd_valid[inst] = v;
        cmd_start[inst] = W'($urandom);
        cmd_end[inst]   = W'($urandom);
        cmd_updn[inst]  = 1'($urandom);
        cmd_mode[inst]  = 1'($urandom);
    endtask

    // Idle cycles: no command; pause/abort toggle randomly and must be ignored.
    task automatic idle(int inst, int n);
        repeat (n) begin
            noise(inst, 1'b0);
            pause[inst] = 1'($urandom);
            abort[inst] = 1'($urandom);
            push(inst, m_count[inst], m_dir[inst], 1'b0, 1'b0, 1'b0);
            m_fin[inst] = 1'b0;
            next_cycle();
        end
    endtask

    // One command from presentation to completion or abort. Cycle i is the
    // i-th edge after acceptance; a step happens whenever the number of
    // unpaused running cycles reaches a multiple of the divide ratio.
    task automatic run_cmd(int inst, int s, int e, bit u, bit md,
                           int pause_pct, int pw_lo, int pw_hi, int abort_at);
        int div, active, tgt;
        bit p, a, d, t;
        div    = (inst == 0) ? 1 : 3;
        active = 0;
        tgt    = e;
        cmd_valid[inst] = 1'b1;
        cmd_start[inst] = W'(s);
        cmd_end[inst]   = W'(e);
        cmd_updn[inst]  = u;
        cmd_mode[inst]  = md;
        pause[inst]     = 1'($urandom);
        abort[inst]     = 1'($urandom);
        if (m_fin[inst]) begin
            // Command held through the completion cycle: ignored until idle.
            push(inst, m_count[inst], m_dir[inst], 1'b0, 1'b0, 1'b0);
            m_fin[inst] = 1'b0;
            next_cycle();
        end
        m_count[inst] = s;
        m_dir[inst]   = u;
        if (s == e) begin
            push(inst, s, u, 1'b1, 1'b1, 1'b0);
            m_fin[inst] = 1'b1;
            next_cycle();
            cmd_valid[inst] = 1'b0;
            return;
        end
        push(inst, s, u, 1'b1, 1'b0, 1'b0);
        next_cycle();
        for (int i = 1; i < 400; i++) begin
            p = (i >= pw_lo && i < pw_hi) || ($urandom_range(99) < pause_pct);
            a = (i == abort_at);
            noise(inst, 1'($urandom));
            pause[inst] = p;
            abort[inst] = a;
            if (a) begin
                push(inst, m_count[inst], m_dir[inst], 1'b0, 1'b0, 1'b0);
                next_cycle();
                cmd_valid[inst] = 1'b0;
                abort[inst]     = 1'b0;
                return;
            end
            d = 1'b0;
            t = 1'b0;
            if (!p) begin
                active++;
                if (active % div == 0) begin
                    m_count[inst] = (m_count[inst] + (m_dir[inst] ? 1 : MASK)) & MASK;
                    if (m_count[inst] == tgt) begin
                        if (!md) begin
                            d = 1'b1;
                        end else begin
                            m_dir[inst] = !m_dir[inst];
                            tgt = (tgt == e) ? s : e;
                            t = 1'b1;
                        end
                    end
                end
            end
            push(inst, m_count[inst], m_dir[inst], 1'b1, d, t);
            next_cycle();
            if (d) begin
                m_fin[inst]     = 1'b1;
                cmd_valid[inst] = 1'b0;
                abort[inst]     = 1'b0;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL run_cmd inst%0d sequence did not end: got still running, expected completion", inst);
    endtask

    task automatic random_cmds(int inst, int n);
        int s, e, at;
        bit md;
        repeat (n) begin
            s  = $urandom_range(0, MASK);
            e  = $urandom_range(0, MASK);
            md = 1'($urandom);
            if (md) at = $urandom_range(3, 60);
            else    at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
            run_cmd(inst, s, e, 1'($urandom), md, $urandom_range(0, 30), 0, 0, at);
            idle(inst, $urandom_range(0, 2));
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        cmd_valid = '0;
        cmd_updn  = '0;
        cmd_mode  = '0;
        pause     = '0;
        abort     = '0;
        cmd_start = '0;
        cmd_end   = '0;
        for (int k = 0; k < 2; k++) begin
            m_count[k] = 0;
            m_dir[k]   = 1'b1;
            m_fin[k]   = 1'b0;
        end
        #1 rst_n = 1'b0;
        #2;
        compare(0, "reset_async", mk(0, 1'b1, 1'b0, 1'b0, 1'b0));
        compare(1, "reset_async", mk(0, 1'b1, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(0, 2);

        // DIV=1 directed sequences
        run_cmd(0, 3, 7, 1'b1, 1'b0, 0, 0, 0, 0);      // one-shot up 3..7
        idle(0, 2);
        run_cmd(0, 14, 1, 1'b1, 1'b0, 0, 0, 0, 0);     // wrap up
        run_cmd(0, 1, 14, 1'b0, 1'b0, 0, 0, 0, 0);     // wrap down, held through FINISH
        idle(0, 1);
        run_cmd(0, 5, 2, 1'b0, 1'b1, 0, 0, 0, 8);      // bounce, abort at count 4
        idle(0, 1);
        run_cmd(0, 9, 9, 1'b1, 1'b1, 0, 0, 0, 0);      // zero-length
        idle(0, 2);
        random_cmds(0, 15);
        idle(0, 1);

        // Reset in the middle of a running sequence at count 6
        noise(0, 1'b1);
        cmd_start[0] = 4'd4;
        cmd_end[0]   = 4'd12;
        cmd_updn[0]  = 1'b1;
        cmd_mode[0]  = 1'b0;
        pause[0]     = 1'b0;
        abort[0]     = 1'b0;
        push(0, 4, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        cmd_valid[0] = 1'b0;
        push(0, 5, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        push(0, 6, 1'b1, 1'b1, 1'b0, 1'b0);
        next_cycle();
        #3 rst_n = 1'b0;
        #1;
        compare(0, "reset_mid_run", mk(0, 1'b1, 1'b0, 1'b0, 1'b0));
        compare(1, "reset_mid_run", mk(0, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int k = 0; k < 2; k++) begin
            m_count[k] = 0;
            m_dir[k]   = 1'b1;
            m_fin[k]   = 1'b0;
        end
        idle(0, 2);
        rst_n = 1'b1;
        idle(0, 1);
        run_cmd(0, 2, 6, 1'b1, 1'b0, 0, 0, 0, 0);
        idle(0, 1);

        // DIV=3 directed and random sequences
        idle(1, 1);
        run_cmd(1, 0, 3, 1'b1, 1'b0, 0, 4, 8, 0);      // pause for 4 cycles after first step
        idle(1, 1);
        random_cmds(1, 15);
        idle(1, 2);

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d/%0d pending expectations, expected 0/0", q0.size(), q1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/up_down_sequencer.md
UP_DOWN_SEQUENCER -- requirements
Module: up_down_sequencer

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, default 4, counter width in bits.
- DIV, default 1, clock cycles per count step; legal values are 1..255.

REQ-002 Ports SHALL be, one per line:
- CLK  in  1  single clock, all state updates on rising edge.
- RESET  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  command accepted when CMD_VALID and CMD_READY are both high at a rising edge.
- CMD_START  in  WIDTH  first count value.
- CMD_END  in  WIDTH  target count value.
- CMD_UPDN  in  1  initial direction: 1 is up, 0 is down.
- CMD_MODE  in  1  0 is one-shot, 1 is bounce.
- PAUSE  in  1  freeze stepping.
- ABORT  in  1  terminate the active sequence.
- COUNT  out  WIDTH  current count, registered.
- UPDN  out  1  current direction, registered.
- BUSY  out  1  sequence active.
- DONE  out  1  one-cycle completion pulse.
- TURN  out  1  one-cycle direction-reversal pulse.

REQ-003 Clock and reset SHALL be exactly as decided: one clock; reset is asynchronous and active-low.

Function
REQ-004 FSM states SHALL be IDLE, RUN and FINISH; every output except CMD_READY SHALL be registered.
REQ-005 CMD_READY SHALL be 1 only in IDLE.
REQ-006 BUSY SHALL be 1 in RUN and in FINISH.
REQ-007 In IDLE, command acceptance SHALL load COUNT<=CMD_START and UPDN<=CMD_UPDN, latch CMD_START, CMD_END and CMD_MODE, and clear the divider.
REQ-008 After acceptance, the FSM SHALL go to RUN, or to FINISH if CMD_START==CMD_END, in either mode.
REQ-009 In RUN, a step tick SHALL occur on the edge where the divider equals DIV-1 and PAUSE=0.
REQ-010 The divider SHALL wrap to 0 on a tick.
REQ-011 While PAUSE=1, the divider and COUNT SHALL both hold.
REQ-012 On a tick, COUNT SHALL step by +1 if UPDN=1 or -1 if UPDN=0, modulo 2^WIDTH; both 15->0 up and 0->15 down SHALL wrap freely.
REQ-013 In one-shot mode, the edge on which COUNT becomes CMD_END SHALL move the FSM to FINISH.
REQ-014 In bounce mode, the edge on which COUNT becomes the current target SHALL invert UPDN, swap the target between latched START and END, and assert TURN for that one cycle; the FSM SHALL stay in RUN.
REQ-015 FINISH SHALL last exactly one cycle, with DONE=1; DONE therefore coincides with the first cycle COUNT==CMD_END. The FSM SHALL then go to IDLE.
REQ-016 ABORT=1 in RUN SHALL take priority over a tick and over PAUSE: next state IDLE, COUNT and UPDN hold, no DONE or TURN.
REQ-017 ABORT SHALL be ignored in IDLE and in FINISH.
REQ-018 CMD_VALID SHALL be ignored outside IDLE; a command held valid through FINISH SHALL be accepted on the first IDLE edge.
REQ-019 COUNT SHALL change only on a tick or on command acceptance.
REQ-020 Latency: with acceptance at edge n and DIV=1, COUNT SHALL equal CMD_START after edge n, and the first step SHALL occur at edge n+1; in general the first step SHALL occur at edge n+DIV.

Reset
REQ-021 While RESET=0, immediately and independent of CLK, the block SHALL hold:
- state=IDLE, so CMD_READY=1.
- COUNT=0 and UPDN=1.
- BUSY=0, DONE=0, TURN=0.
- divider=0, latched START/END=0, latched MODE=0.
REQ-022 Release of RESET SHALL take effect at the next rising CLK edge; no step SHALL occur on the release edge.
REQ-023 Reset assertion during RUN or FINISH SHALL discard the sequence and produce no DONE.

Verification
REQ-024 One-shot up, DIV=1, START=3, END=7 -> COUNT 3,4,5,6,7 on consecutive cycles; DONE=1 only while COUNT=7; BUSY falls one cycle later; CMD_READY then returns to 1.
REQ-025 Wrap, DIV=1, START=14, END=1, UPDN=1 -> COUNT 14,15,0,1; DONE with COUNT=1. Down variant START=1, END=14 -> COUNT 1,0,15,14.
REQ-026 Bounce down, START=5, END=2:
- COUNT sequence 5,4,3,2,3,4,5,4.
- TURN=1 with COUNT=2 (UPDN becomes 1) and with COUNT=5 (UPDN becomes 0).
- ABORT at COUNT=4 -> IDLE next edge, COUNT stays 4, DONE never asserted.
REQ-027 DIV=3, one-shot up, START=0, END=3, PAUSE high for 4 cycles after first step -> COUNT holds at 1 for 3+4 cycles, then steps resume every 3 cycles; DONE with COUNT=3.
REQ-028 START=END=9 -> FINISH immediately after acceptance: COUNT=9, DONE=1 for one cycle, no tick, no TURN.
REQ-029 RESET low for 2 cycles while COUNT=6 in RUN -> outputs match REQ-021 asynchronously, with no DONE; a new command after release is accepted normally.
